// File: rtl/ghost_dir_chooser_if.sv
// Bundle of the per-ghost inputs (frame/sec timing, wall probes, positions)
// and the chosen direction / phase outputs.
interface ghost_dir_chooser_if;
  logic       frame_clk;
  logic       sec;
  logic       restart;
  logic       lifeDown;
  logic [4:0] mapL;
  logic [4:0] mapR;
  logic [4:0] mapB;
  logic [4:0] mapT;
  logic [9:0] ghostX;
  logic [9:0] ghostY;
  logic [9:0] targetX;
  logic [9:0] targetY;
  logic [7:0] randomkeycode;
  logic [1:0] phase;

  // Driver side: supplies timing, probes and positions, observes the choice.
  modport master (
    output frame_clk, sec, restart, lifeDown,
    output mapL, mapR, mapB, mapT,
    output ghostX, ghostY, targetX, targetY,
    input  randomkeycode, phase
  );

  // Chooser side.
  modport slave (
    input  frame_clk, sec, restart, lifeDown,
    input  mapL, mapR, mapB, mapT,
    input  ghostX, ghostY, targetX, targetY,
    output randomkeycode, phase
  );
endinterface

// File: rtl/ghost_dir_chooser.sv
// Ghost direction chooser: on each frame tick picks L/R/D/U from the wall
// probes, steering toward a target in CHASE and LFSR-random in ROAM, with a
// timed RELEASE/CHASE/ROAM phase machine driven by one-second pulses.
// Directions are held internally as one-hot vectors, bit0=U bit1=L bit2=D
// bit3=R, which is also the U,L,D,R fallback priority order.
module ghost_dir_chooser #(
  parameter int unsigned RELEASE_SECS = 3,
  parameter int unsigned CHASE_SECS   = 20,
  parameter int unsigned ROAM_SECS    = 7,
  parameter int unsigned MIN_HOLD     = 8,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input logic             Clk,
  input logic             Reset,
  ghost_dir_chooser_if.slave bus
);
  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_L    = 8'h04;
  localparam logic [7:0] KEY_R    = 8'h07;
  localparam logic [7:0] KEY_D    = 8'h16;
  localparam logic [7:0] KEY_U    = 8'h1A;

  localparam int unsigned SEC_MAX =
    (CHASE_SECS > ROAM_SECS) ? ((CHASE_SECS > RELEASE_SECS) ? CHASE_SECS : RELEASE_SECS)
                             : ((ROAM_SECS > RELEASE_SECS) ? ROAM_SECS : RELEASE_SECS);
  localparam int unsigned SEC_W  = $clog2(SEC_MAX + 1);
  localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);

  typedef enum logic [1:0] {
    ST_RELEASE = 2'd0,
    ST_CHASE   = 2'd1,
    ST_ROAM    = 2'd2
  } state_t;

  function automatic logic [3:0] key_to_dir(input logic [7:0] key);
    case (key)
      KEY_U:   return 4'b0001;
      KEY_L:   return 4'b0010;
      KEY_D:   return 4'b0100;
      KEY_R:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] dir_to_key(input logic [3:0] dir);
    case (dir)
      4'b0001: return KEY_U;
      4'b0010: return KEY_L;
      4'b0100: return KEY_D;
      4'b1000: return KEY_R;
      default: return KEY_NONE;
    endcase
  endfunction

  // Isolates the lowest set bit, i.e. the first direction in U,L,D,R order.
  function automatic logic [3:0] first_set(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  state_t            state_q, state_d;
  logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        key_q, key_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              frame_s1_q, frame_s2_q, frame_s3_q;
  logic              tick;

  logic [3:0]  open_v, cur_v, rev_v, cand_v;
  logic        cand_le1, tunnel;
  logic [10:0] dx, dy, adx, ady;
  logic [3:0]  tow_x, tow_y, prim_v, sec_v, chase_v, roam_rot, roam_pick, roam_v;
  logic [7:0]  roam_wide, roam_back;
  logic [7:0]  dec_key;
  logic [HOLD_W-1:0] dec_hold;

  assign tick   = frame_s2_q & ~frame_s3_q;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign open_v   = {bus.mapR == 5'd0, bus.mapB == 5'd0, bus.mapL == 5'd0, bus.mapT == 5'd0};
  assign cur_v    = key_to_dir(key_q);
  // Opposite direction: U<->D, L<->R. With no current direction there is nothing to exclude.
  assign rev_v    = {cur_v[1], cur_v[0], cur_v[3], cur_v[2]};
  assign cand_v   = open_v & ~rev_v;
  assign cand_le1 = ((cand_v & (cand_v - 4'd1)) == 4'd0);
  assign tunnel   = (bus.ghostY >= 10'd195) && (bus.ghostY <= 10'd223) &&
                    ((bus.ghostX <= 10'd10) || (bus.ghostX >= 10'd390));

  // Target deltas in 11-bit two's complement; the sign bit picks the toward direction.
  assign dx     = {1'b0, bus.targetX} - {1'b0, bus.ghostX};
  assign dy     = {1'b0, bus.targetY} - {1'b0, bus.ghostY};
  assign adx    = dx[10] ? (~dx + 11'd1) : dx;
  assign ady    = dy[10] ? (~dy + 11'd1) : dy;
  assign tow_x  = (dx == 11'd0) ? 4'b0000 : (dx[10] ? 4'b0010 : 4'b1000);
  assign tow_y  = (dy == 11'd0) ? 4'b0000 : (dy[10] ? 4'b0001 : 4'b0100);
  assign prim_v = (adx >= ady) ? tow_x : tow_y;
  assign sec_v  = (adx >= ady) ? tow_y : tow_x;

  // Roam: rotate candidates so the LFSR-selected start is bit0, take the first, rotate back.
  assign roam_wide = {cand_v, cand_v} >> lfsr_q[1:0];
  assign roam_rot  = roam_wide[3:0];
  assign roam_pick = first_set(roam_rot);
  assign roam_back = {roam_pick, roam_pick} << lfsr_q[1:0];
  assign roam_v    = roam_back[7:4];

  // Chase preference: primary toward, secondary toward, then U,L,D,R.
  always_comb begin
    chase_v = first_set(cand_v);
    if ((prim_v & cand_v) != 4'd0) begin
      chase_v = prim_v;
    end else if ((sec_v & cand_v) != 4'd0) begin
      chase_v = sec_v;
    end
  end

  // Direction decision and hold counter update for a tick in CHASE/ROAM.
  always_comb begin
    dec_key  = key_q;
    dec_hold = hold_q;
    if (!tunnel) begin
      if (cand_v == 4'd0) begin
        if ((rev_v & open_v) != 4'd0) begin
          dec_key = dir_to_key(rev_v);
        end
      end else if (((cur_v & open_v) != 4'd0) && (hold_q < HOLD_W'(MIN_HOLD)) && cand_le1) begin
        dec_key = key_q;
      end else if (state_q == ST_CHASE) begin
        dec_key = dir_to_key(chase_v);
      end else begin
        dec_key = dir_to_key(roam_v);
      end
      if (dec_key != key_q) begin
        dec_hold = '0;
      end else if (hold_q != HOLD_W'(MIN_HOLD)) begin
        dec_hold = hold_q + 1'b1;
      end
    end
  end

  // Phase machine on sec pulses, decision capture on ticks, restart/lifeDown override.
  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    key_d     = key_q;
    hold_d    = hold_q;
    if (bus.sec) begin
      sec_cnt_d = sec_cnt_q + 1'b1;
      case (state_q)
        ST_RELEASE: if (sec_cnt_q == SEC_W'(RELEASE_SECS - 1)) begin
          state_d   = ST_CHASE;
          sec_cnt_d = '0;
        end
        ST_CHASE: if (sec_cnt_q == SEC_W'(CHASE_SECS - 1)) begin
          state_d   = ST_ROAM;
          sec_cnt_d = '0;
        end
        ST_ROAM: if (sec_cnt_q == SEC_W'(ROAM_SECS - 1)) begin
          state_d   = ST_CHASE;
          sec_cnt_d = '0;
        end
        default: begin
          state_d   = ST_RELEASE;
          sec_cnt_d = '0;
        end
      endcase
    end
    // Decision uses the pre-update phase (state_q) even when sec lands on the same cycle.
    if (tick && (state_q != ST_RELEASE)) begin
      key_d  = dec_key;
      hold_d = dec_hold;
    end
    if (bus.restart || bus.lifeDown) begin
      state_d   = ST_RELEASE;
      sec_cnt_d = '0;
      key_d     = KEY_NONE;
      hold_d    = '0;
    end
  end

  // State registers; the LFSR is only reseeded by the hard reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_RELEASE;
      sec_cnt_q  <= '0;
      hold_q     <= '0;
      key_q      <= KEY_NONE;
      lfsr_q     <= LFSR_SEED;
      frame_s1_q <= 1'b0;
      frame_s2_q <= 1'b0;
      frame_s3_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_cnt_q  <= sec_cnt_d;
      hold_q     <= hold_d;
      key_q      <= key_d;
      lfsr_q     <= lfsr_d;
      frame_s1_q <= bus.frame_clk;
      frame_s2_q <= frame_s1_q;
      frame_s3_q <= frame_s2_q;
    end
  end

  assign bus.randomkeycode = key_q;
  assign bus.phase         = state_q;
endmodule

// File: tb/tb_ghost_dir_chooser.sv
// Directed bench for ghost_dir_chooser with a behavioural reference model
// and an expected-keycode queue filled at each tick and drained one Clk later.
module tb_ghost_dir_chooser;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ghost_dir_chooser_if bus ();

  ghost_dir_chooser dut (
    .Clk  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference state.
  logic [7:0] m_key;
  int         m_hold;
  int         m_phase;
  int         m_sec;
  logic [7:0] m_lfsr;
  logic [7:0] exp_q[$];
  int         cnt04, cnt07, cnt16, cnt1a, cnt00;
  logic [7:0] got;

  // Shadow of the x^8+x^6+x^5+x^4+1 sequence, stepping every Clk from the seed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int dir_of(input logic [7:0] k);
    case (k)
      8'h1A:   return 0;
      8'h04:   return 1;
      8'h16:   return 2;
      8'h07:   return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] key_of(input int d);
    case (d)
      0:       return 8'h1A;
      1:       return 8'h04;
      2:       return 8'h16;
      default: return 8'h07;
    endcase
  endfunction

  // Reference decision from current inputs, model state and shadow LFSR.
  task automatic model_tick(output logic [7:0] nk);
    bit open_s[4];
    bit cand[4];
    int cur, rv, ncand, dx, dy, adx, ady, xd, yd, d;
    int tries[6];
    bit found, tun;
    nk = m_key;
    if (m_phase == 0) return;
    open_s[0] = (bus.mapT == 0);
    open_s[1] = (bus.mapL == 0);
    open_s[2] = (bus.mapB == 0);
    open_s[3] = (bus.mapR == 0);
    cur = dir_of(m_key);
    rv  = (cur < 0) ? -1 : (cur + 2) % 4;
    ncand = 0;
    for (int i = 0; i < 4; i++) begin
      cand[i] = open_s[i] && (i != rv);
      if (cand[i]) ncand++;
    end
    tun = (bus.ghostY >= 195) && (bus.ghostY <= 223) && ((bus.ghostX <= 10) || (bus.ghostX >= 390));
    if (tun) return;
    if (ncand == 0) begin
      if (rv >= 0 && open_s[rv]) nk = key_of(rv);
    end else if (cur >= 0 && open_s[cur] && m_hold < 8 && ncand <= 1) begin
      nk = m_key;
    end else if (m_phase == 1) begin
      dx  = int'(bus.targetX) - int'(bus.ghostX);
      dy  = int'(bus.targetY) - int'(bus.ghostY);
      adx = (dx < 0) ? -dx : dx;
      ady = (dy < 0) ? -dy : dy;
      xd  = (dx > 0) ? 3 : ((dx < 0) ? 1 : -1);
      yd  = (dy > 0) ? 2 : ((dy < 0) ? 0 : -1);
      tries[0] = (adx >= ady) ? xd : yd;
      tries[1] = (adx >= ady) ? yd : xd;
      for (int i = 0; i < 4; i++) tries[i+2] = i;
      found = 0;
      for (int i = 0; i < 6; i++) begin
        if (!found && tries[i] >= 0 && cand[tries[i]]) begin
          nk = key_of(tries[i]);
          found = 1;
        end
      end
    end else begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        d = (int'(m_lfsr[1:0]) + k) % 4;
        if (!found && cand[d]) begin
          nk = key_of(d);
          found = 1;
        end
      end
    end
    if (nk != m_key) m_hold = 0;
    else if (m_hold < 8) m_hold++;
  endtask

  // One frame pulse: expectation pushed in the tick-detect cycle, compared one Clk later.
  task automatic do_tick(input string tag, output logic [7:0] obs);
    logic [7:0] nk;
    logic [7:0] e;
    @(negedge clk) bus.frame_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_tick(nk);
    exp_q.push_back(nk);
    m_key = nk;
    @(posedge clk);
    #1;
    obs = bus.randomkeycode;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed empty-queue required entry", tag);
    end else begin
      e = exp_q.pop_front();
      check8(tag, obs, e);
    end
    $display("tick %-14s key=%h phase=%0d", tag, obs, bus.phase);
    @(negedge clk) bus.frame_clk = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_sec();
    @(negedge clk) bus.sec = 1'b1;
    @(posedge clk);
    #1;
    m_sec++;
    if (m_phase == 0 && m_sec == 3)       begin m_phase = 1; m_sec = 0; end
    else if (m_phase == 1 && m_sec == 20) begin m_phase = 2; m_sec = 0; end
    else if (m_phase == 2 && m_sec == 7)  begin m_phase = 1; m_sec = 0; end
    check8("sec_phase", {6'b0, bus.phase}, 8'(m_phase));
    $display("sec  phase=%0d key=%h", bus.phase, bus.randomkeycode);
    @(negedge clk) bus.sec = 1'b0;
  endtask

  task automatic pulse_clear(input bit use_life);
    @(negedge clk);
    if (use_life) bus.lifeDown = 1'b1;
    else          bus.restart  = 1'b1;
    @(posedge clk);
    #1;
    m_key = 8'h00; m_hold = 0; m_phase = 0; m_sec = 0;
    check8(use_life ? "lifedown_key" : "restart_key", bus.randomkeycode, 8'h00);
    check8(use_life ? "lifedown_phase" : "restart_phase", {6'b0, bus.phase}, 8'h00);
    $display("clear %s key=%h phase=%0d", use_life ? "lifeDown" : "restart", bus.randomkeycode, bus.phase);
    @(negedge clk);
    bus.lifeDown = 1'b0;
    bus.restart  = 1'b0;
  endtask

  task automatic set_maps(input logic [4:0] l, input logic [4:0] r, input logic [4:0] b, input logic [4:0] t);
    bus.mapL = l; bus.mapR = r; bus.mapB = b; bus.mapT = t;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.frame_clk = 1'b0; bus.sec = 1'b0; bus.restart = 1'b0; bus.lifeDown = 1'b0;
    set_maps(5'd0, 5'd0, 5'd0, 5'd0);
    bus.ghostX = 10'd142; bus.ghostY = 10'd166;
    bus.targetX = 10'd300; bus.targetY = 10'd170;
    m_key = 8'h00; m_hold = 0; m_phase = 0; m_sec = 0;
    cnt04 = 0; cnt07 = 0; cnt16 = 0; cnt1a = 0; cnt00 = 0;
    repeat (3) @(posedge clk);
    #1;
    check8("reset_key", bus.randomkeycode, 8'h00);
    check8("reset_phase", {6'b0, bus.phase}, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // Release delay.
    pulse_sec();
    pulse_sec();
    do_tick("release_tick", got);
    check8("release_idle", got, 8'h00);
    pulse_sec();
    check8("chase_entered", {6'b0, bus.phase}, 8'h01);

    // Chase toward target.
    do_tick("chase_first", got);
    check8("chase_first_R", got, 8'h07);
    bus.mapR = 5'd1;
    bus.targetY = 10'd20;
    do_tick("chase_up", got);
    check8("chase_up_U", got, 8'h1A);
    bus.mapR = 5'd0;
    bus.targetX = 10'd0; bus.targetY = 10'd166;
    do_tick("chase_left", got);
    check8("chase_left_L", got, 8'h04);

    // Corridor hold, then reverse fallback.
    set_maps(5'd0, 5'd0, 5'd1, 5'd1);
    for (int i = 0; i < 20; i++) begin
      do_tick("corridor", got);
      check8("corridor_L", got, 8'h04);
    end
    bus.mapL = 5'd1;
    do_tick("dead_end", got);
    check8("reverse_R", got, 8'h07);

    // Tunnel hold.
    set_maps(5'd0, 5'd1, 5'd1, 5'd1);
    do_tick("back_left", got);
    check8("back_left_L", got, 8'h04);
    bus.ghostX = 10'd8; bus.ghostY = 10'd210;
    set_maps(5'd1, 5'd1, 5'd1, 5'd0);
    for (int i = 0; i < 4; i++) begin
      do_tick("tunnel", got);
      check8("tunnel_hold", got, 8'h04);
    end
    bus.ghostX = 10'd395; bus.ghostY = 10'd200;
    do_tick("tunnel_right", got);
    check8("tunnel_hold_r", got, 8'h04);

    // Turn down, then roam.
    bus.ghostX = 10'd142; bus.ghostY = 10'd166;
    bus.targetX = 10'd142; bus.targetY = 10'd400;
    set_maps(5'd0, 5'd0, 5'd0, 5'd0);
    do_tick("chase_down", got);
    check8("chase_down_D", got, 8'h16);
    for (int i = 0; i < 20; i++) pulse_sec();
    check8("roam_entered", {6'b0, bus.phase}, 8'h02);
    for (int i = 0; i < 256; i++) begin
      do_tick("roam", got);
      case (got)
        8'h04:   cnt04++;
        8'h07:   cnt07++;
        8'h16:   cnt16++;
        8'h1A:   cnt1a++;
        default: cnt00++;
      endcase
    end
    check8("roam_cnt04", {7'b0, cnt04 >= 10}, 8'h01);
    check8("roam_cnt07", {7'b0, cnt07 >= 10}, 8'h01);
    check8("roam_cnt16", {7'b0, cnt16 >= 10}, 8'h01);
    check8("roam_none", 8'(cnt00), 8'h00);

    // Back to chase, then life loss.
    for (int i = 0; i < 7; i++) pulse_sec();
    check8("chase_again", {6'b0, bus.phase}, 8'h01);
    set_maps(5'd1, 5'd0, 5'd1, 5'd1);
    do_tick("only_right", got);
    check8("only_right_R", got, 8'h07);
    pulse_sec();
    pulse_clear(1'b1);
    pulse_sec();
    pulse_sec();
    check8("release_after_life", {6'b0, bus.phase}, 8'h00);
    pulse_sec();
    check8("sec_cnt_cleared", {6'b0, bus.phase}, 8'h01);
    do_tick("first_after_rel", got);
    check8("first_after_rel_R", got, 8'h07);
    pulse_clear(1'b0);
    for (int i = 0; i < 3; i++) pulse_sec();
    do_tick("pre_reset", got);

    // Async reset during a tick-detect cycle.
    @(negedge clk) bus.frame_clk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check8("async_key", bus.randomkeycode, 8'h00);
    check8("async_phase", {6'b0, bus.phase}, 8'h00);
    $display("async reset key=%h phase=%0d", bus.randomkeycode, bus.phase);
    m_key = 8'h00; m_hold = 0; m_phase = 0; m_sec = 0;
    @(negedge clk) bus.frame_clk = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check8("post_reset_key", bus.randomkeycode, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
